uart_frame_parser: RTL and testbench

// - Consumes bytes from the UART receiver (8-bit data + one-cycle valid strobe); sits between rx and the application/tx path.
// - Parses frames: 0x55, 0xAA, LEN, LEN payload bytes, CHK.
// - Buffers the payload. Releases it only after the checksum verifies, as a burst of one byte per clock. Reports framing errors.

---
 rtl/uart_frame_pkg.sv | 23 ++
 rtl/uart_frame_buf.sv | 47 ++++
 rtl/uart_frame_parser.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART frame parser.
// Frame layout on the wire: HDR0, HDR1, LEN, LEN payload bytes, CHK,
// where CHK = (LEN + sum of payload bytes) mod 256.
package uart_frame_pkg;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  // ST_ prefix keeps the state names clear of the HDR0/HDR1 byte constants.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one registered read port. The read register holds its value while rd_en_i
// is low, so the last byte read stays on rd_data_o between reads.
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset (clears the read register only)
//   wr_en_i    write strobe; wr_data_i is stored at wr_addr_i
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe; mem[rd_addr_i] appears on rd_data_o next cycle
//   rd_addr_i  read address
//   rd_data_o  registered read data
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // NOTE: the storage array has no reset; every location is written before
  // it is read within a frame, and a reset port on it would only add muxes.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser. Accepts bytes from a UART receiver, recognises frames
// 55 AA LEN payload[LEN] CHK, buffers the payload and, once the checksum
// matches, replays it as a burst of one byte per clock. Bad LEN, bad
// checksum and inter-byte timeout each raise a one-cycle frame_err.
//   sys_clk    clock, rising edge
//   sys_rst    synchronous active-high reset
//   pi_data    received byte, valid with pi_flag
//   pi_flag    one-cycle byte strobe
//   po_data    payload byte (holds when po_flag is low)
//   po_flag    payload byte strobe
//   po_last    final payload byte of the frame
//   frame_ok   pulse with po_last of a verified frame
//   frame_err  one-cycle error pulse
//   err_code   1 bad LEN, 2 bad checksum, 3 timeout; holds between errors
// All outputs are registered. MAX_LEN must stay below 256.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CNT = 156240
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       po_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CNT);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CNT - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;        // next payload write slot
  logic [LW-1:0] rd_idx_q, rd_idx_d;  // next payload slot to replay
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          po_flag_q, po_flag_d;
  logic          po_last_q, po_last_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          buf_wr_en, buf_rd_en;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;

  logic          tmo_active, tmo_expire;
  logic [TW-1:0] tmo_inc;
  logic          len_ok, data_last, chk_ok, drain_last;

  assign tmo_active = (state_q == ST_HDR1) || (state_q == ST_LEN) ||
                      (state_q == ST_DATA) || (state_q == ST_CHK);
  assign tmo_inc    = tmo_q + TW'(1);
  // Expiry is the cycle the counter would reach TIMEOUT_CNT-1; a strobe in
  // that same cycle clears the counter instead and the frame carries on.
  assign tmo_expire = tmo_active && !pi_flag && (tmo_inc == TMO_LAST);

  assign len_ok     = (pi_data != 8'd0) && (pi_data <= MAX_LEN_B);
  assign data_last  = (idx_q == len_q - LW'(1));
  assign chk_ok     = (pi_data == sum_q);
  assign drain_last = (rd_idx_q == len_q - LW'(1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      po_flag_q   <= 1'b0;
      po_last_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      po_flag_q   <= po_flag_d;
      po_last_q   <= po_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default at
  // the top, so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pi_flag && pi_data == HDR0) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        if (tmo_expire) begin
          state_d = ST_IDLE;
        end else if (pi_flag) begin
          if (pi_data == HDR1)      state_d = ST_LEN;
          else if (pi_data != HDR0) state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (tmo_expire)   state_d = ST_IDLE;
        else if (pi_flag) state_d = len_ok ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        if (tmo_expire)                  state_d = ST_IDLE;
        else if (pi_flag && data_last)   state_d = ST_CHK;
      end
      ST_CHK: begin
        // The first beat leaves on the checksum edge itself, so a one-byte
        // payload has nothing left to drain and returns straight to idle.
        if (tmo_expire) begin
          state_d = ST_IDLE;
        end else if (pi_flag) begin
          state_d = (chk_ok && len_q != LW'(1)) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-state.
  always_comb begin
    len_d       = len_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    sum_d       = sum_q;
    tmo_d       = (tmo_active && !pi_flag) ? tmo_inc : '0;
    po_flag_d   = 1'b0;
    po_last_d   = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_wr_en   = 1'b0;
    buf_wr_addr = idx_q[AW-1:0];
    buf_rd_en   = 1'b0;
    buf_rd_addr = rd_idx_q[AW-1:0];

    if (tmo_expire) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TMO;
      tmo_d       = '0;
    end

    case (state_q)
      ST_LEN: begin
        if (pi_flag) begin
          if (len_ok) begin
            len_d = pi_data[LW-1:0];
            sum_d = pi_data;
            idx_d = '0;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end
        end
      end
      ST_DATA: begin
        if (pi_flag) begin
          buf_wr_en = 1'b1;
          sum_d     = sum_q + pi_data;
          idx_d     = idx_q + LW'(1);
        end
      end
      ST_CHK: begin
        if (pi_flag) begin
          if (chk_ok) begin
            buf_rd_en   = 1'b1;
            buf_rd_addr = '0;
            rd_idx_d    = LW'(1);
            po_flag_d   = 1'b1;
            po_last_d   = (len_q == LW'(1));
            frame_ok_d  = (len_q == LW'(1));
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
      end
      ST_DRAIN: begin
        buf_rd_en  = 1'b1;
        rd_idx_d   = rd_idx_q + LW'(1);
        po_flag_d  = 1'b1;
        po_last_d  = drain_last;
        frame_ok_d = drain_last;
      end
      default: ;
    endcase
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (buf_wr_addr),
    .wr_data_i (pi_data),
    .rd_en_i   (buf_rd_en),
    .rd_addr_i (buf_rd_addr),
    .rd_data_o (po_data)
  );

  assign po_flag   = po_flag_q;
  assign po_last   = po_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser. A byte-level reference model
// collects each frame in a queue, decides its fate from the frame rules and
// schedules the expected outputs by clock edge; every output is compared
// after every edge. TIMEOUT_CNT is scaled down so the run stays short.
module tb_uart_frame_parser;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CNT = 64;
  localparam int MAXC        = 60000;

  typedef logic [7:0] bq_t[$];

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic [7:0] po_data;
  logic       po_flag, po_last, frame_ok, frame_err;
  logic [1:0] err_code;

  uart_frame_parser #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CNT (TIMEOUT_CNT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pi_data   (pi_data),
    .pi_flag   (pi_flag),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .po_last   (po_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  // Expected events indexed by the clock edge after which they are visible.
  bit         ev_rst  [MAXC];
  bit         ev_flag [MAXC];
  logic [7:0] ev_data [MAXC];
  bit         ev_last [MAXC];
  bit         ev_err  [MAXC];
  logic [1:0] ev_code [MAXC];

  logic [7:0] frame_q[$];     // bytes of the frame currently being received
  int         last_act  = 0;  // edge of the most recent accepted strobe
  int         drain_end = -1; // last edge of the current payload burst
  logic [7:0] hold_data = '0;
  logic [1:0] hold_code = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, obs, exp);
  endtask

  task automatic raise_err(input int e, input logic [1:0] code);
    ev_err[e]  = 1'b1;
    ev_code[e] = code;
  endtask

  task automatic accept_byte(input int e, input logic [7:0] b);
    int n;
    int len;
    logic [7:0] sum;
    n = frame_q.size();
    last_act = e;
    if (n == 0) begin
      if (b == 8'h55) frame_q.push_back(b);
    end else if (n == 1) begin
      if (b == 8'hAA) frame_q.push_back(b);
      else if (b != 8'h55) frame_q.delete();
    end else if (n == 2) begin
      if (b >= 1 && b <= MAX_LEN) frame_q.push_back(b);
      else begin
        raise_err(e, 2'd1);
        frame_q.delete();
      end
    end else begin
      len = int'(frame_q[2]);
      if (n < 3 + len) begin
        frame_q.push_back(b);
      end else begin
        sum = 8'd0;
        for (int i = 2; i < n; i++) sum = sum + frame_q[i];
        if (b == sum) begin
          for (int k = 0; k < len; k++) begin
            ev_flag[e + k] = 1'b1;
            ev_data[e + k] = frame_q[3 + k];
          end
          ev_last[e + len - 1] = 1'b1;
          drain_end = e + len - 1;
        end else begin
          raise_err(e, 2'd2);
        end
        frame_q.delete();
      end
    end
  endtask

  task automatic model_edge(input bit rst, input bit flag, input logic [7:0] b);
    int e;
    e = edge_n;
    if (rst) begin
      ev_rst[e] = 1'b1;
      for (int k = e; k <= e + MAX_LEN + 1; k++) begin
        ev_flag[k] = 1'b0;
        ev_last[k] = 1'b0;
      end
      frame_q.delete();
      drain_end = -1;
    end else if (e <= drain_end) begin
      // bytes arriving during a burst are dropped
    end else if (flag) begin
      accept_byte(e, b);
    end else if (frame_q.size() > 0 && e == last_act + TIMEOUT_CNT - 1) begin
      raise_err(e, 2'd3);
      frame_q.delete();
    end
  endtask

  task automatic compare_outputs();
    int e;
    e = edge_n;
    if (ev_rst[e]) begin
      hold_data = '0;
      hold_code = '0;
    end else begin
      if (ev_flag[e]) hold_data = ev_data[e];
      if (ev_err[e])  hold_code = ev_code[e];
    end
    check("po_flag",   po_flag,   ev_flag[e]);
    check("po_data",   po_data,   hold_data);
    check("po_last",   po_last,   ev_last[e]);
    check("frame_ok",  frame_ok,  ev_last[e]);
    check("frame_err", frame_err, ev_err[e]);
    check("err_code",  err_code,  hold_code);
  endtask

  task automatic step(input bit rst, input bit flag, input logic [7:0] b);
    if (edge_n >= MAXC - MAX_LEN - 3) begin
      n_checks++;
      $display("FAIL cycle_budget edge=%0d got=exhausted expected=within %0d", edge_n, MAXC);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
    sys_rst = rst;
    pi_flag = flag;
    pi_data = flag ? b : 8'($urandom);
    @(posedge sys_clk);
    edge_n++;
    model_edge(rst, flag, b);
    @(negedge sys_clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b0, 1'b1, b);
    idle(gap - 1);
  endtask

  task automatic send_seq(input bq_t q, input int gmin, input int gmax);
    foreach (q[i]) send(q[i], int'($urandom_range(gmax, gmin)));
  endtask

  function automatic bq_t make_frame(input int len, input bit corrupt);
    bq_t q;
    logic [7:0] sum;
    logic [7:0] d;
    q = {8'h55, 8'hAA, 8'(len)};
    sum = 8'(len);
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      sum = sum + d;
    end
    q.push_back(corrupt ? (sum ^ 8'h01) : sum);
    return q;
  endfunction

  initial begin
    bq_t q;
    int kind;
    sys_rst = 1'b1;
    pi_flag = 1'b0;
    pi_data = 8'h00;

    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(3);

    // Good frame, then bad checksum, then good again.
    send_seq({8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 10, 10);
    send_seq({8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}, 10, 10);
    send_seq({8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 10, 10);

    // Illegal lengths; trailing bytes ignored until the next header.
    send_seq({8'h55, 8'hAA, 8'h00, 8'h12, 8'h34}, 10, 10);
    send_seq({8'h55, 8'hAA, 8'h11, 8'h12, 8'h34, 8'h56}, 10, 10);
    send_seq({8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80}, 10, 10);

    // Timeout mid-payload, then recovery.
    send_seq({8'h55, 8'hAA, 8'h02, 8'h01}, 10, 10);
    idle(TIMEOUT_CNT + 10);
    send_seq({8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80}, 10, 10);

    // Strobe exactly on the expiry cycle survives; one cycle later does not.
    send_seq({8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h05}, TIMEOUT_CNT - 1, TIMEOUT_CNT - 1);
    idle(5);
    send_seq({8'h55, 8'hAA, 8'h02, 8'h01}, TIMEOUT_CNT, TIMEOUT_CNT);
    idle(TIMEOUT_CNT);

    // Resync and leading noise.
    send_seq({8'h00, 8'hFF, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80}, 10, 10);

    // Reset mid-payload, then a good frame.
    send_seq({8'h55, 8'hAA, 8'h03, 8'h11}, 10, 10);
    step(1'b1, 1'b0, 8'h00);
    send_seq({8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 10, 10);

    // Max length with bytes strobed during the burst; then reset mid-burst.
    q = make_frame(MAX_LEN, 1'b0);
    send_seq(q, 1, 1);
    send_seq({8'h55, 8'hAA, 8'h01}, 1, 1);
    idle(MAX_LEN + 2);
    q = make_frame(MAX_LEN, 1'b0);
    send_seq(q, 1, 3);
    idle(2);
    step(1'b1, 1'b0, 8'h00);
    idle(MAX_LEN + 2);

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(9, 0));
      case (kind)
        0: begin
          q = {8'($urandom), 8'($urandom), 8'($urandom)};
          send_seq(q, 1, 20);
        end
        1: begin
          q = {8'h55, 8'hAA, ($urandom_range(1, 0) != 0) ? 8'h00 : 8'($urandom_range(255, MAX_LEN + 1))};
          send_seq(q, 1, 20);
        end
        2: send_seq(make_frame(int'($urandom_range(MAX_LEN, 1)), 1'b1), 1, 20);
        3: begin
          q = make_frame(int'($urandom_range(MAX_LEN, 1)), 1'b0);
          q = q[0:int'($urandom_range(q.size() - 2, 1))];
          send_seq(q, 1, 20);
          idle(TIMEOUT_CNT + 5);
        end
        default: send_seq(make_frame(int'($urandom_range(MAX_LEN, 1)), 1'b0), 1, 20);
      endcase
    end
    idle(TIMEOUT_CNT + MAX_LEN + 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
